// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Shared types and defaults for the fetch sequencing controller.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_REDIR = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  localparam word_t       c_reset_pc   = 32'h0000_0000;
  localparam word_t       c_exc_vector = 32'h0000_0080;
  localparam int unsigned c_boot_hold  = 4;

  // Sequential successor; the add wraps naturally at 32 bits.
  function automatic word_t seq_pc(input word_t pc);
    return pc + 32'd4;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl_if
// Purpose  : Fetch-control bundle; irq/eret/epc exist only with FETCH_CTRL_IRQ_EN.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_ctrl_if;
  import pipe_pkg::*;

  word_t pc;
  logic  hazard_stall;
  logic  ex_branch_taken;
  word_t ex_branch_target;
  logic  id_jump;
  word_t id_jump_target;
  logic  halt_req;
  logic  resume;
`ifdef FETCH_CTRL_IRQ_EN
  logic  irq;
  logic  eret;
  word_t epc;
`endif
  word_t pc_next;
  logic  stall;
  logic  flush_if;
  logic  flush_id;
  logic  halted;

  modport master (
    input  pc, hazard_stall, ex_branch_taken, ex_branch_target,
           id_jump, id_jump_target, halt_req, resume,
`ifdef FETCH_CTRL_IRQ_EN
    input  irq, eret,
    output epc,
`endif
    output pc_next, stall, flush_if, flush_id, halted
  );

  modport slave (
    output pc, hazard_stall, ex_branch_taken, ex_branch_target,
           id_jump, id_jump_target, halt_req, resume,
`ifdef FETCH_CTRL_IRQ_EN
    output irq, eret,
    input  epc,
`endif
    input  pc_next, stall, flush_if, flush_id, halted
  );

endinterface
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Purpose  : Next-PC select, fetch stall/flush, boot hold and halt sequencing.
//            Interrupt entry/return is built only with FETCH_CTRL_IRQ_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_ctrl
  import pipe_pkg::*;
#(
  parameter word_t       RESET_PC   = c_reset_pc,
`ifdef FETCH_CTRL_IRQ_EN
  parameter word_t       EXC_VECTOR = c_exc_vector,
`endif
  parameter int unsigned BOOT_HOLD  = c_boot_hold
) (
  input  logic          clk,
  input  logic          rst,
  fetch_ctrl_if.master  bus
);

  localparam logic [3:0] c_boot_last = 4'(BOOT_HOLD - 1);

  fetch_state_e state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         halted_q;

  word_t pc_next_w;
  logic  stall_w;
  logic  flush_if_w;
  logic  flush_id_w;

`ifdef FETCH_CTRL_IRQ_EN
  word_t epc_q, epc_d;
  logic  int_active_q, int_active_d;
  logic  irq_take;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_BOOT;
      cnt_q    <= 4'd0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      halted_q <= (state_d == ST_HALT);
    end
  end

`ifdef FETCH_CTRL_IRQ_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      epc_q        <= '0;
      int_active_q <= 1'b0;
    end else begin
      epc_q        <= epc_d;
      int_active_q <= int_active_d;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_next_w  = seq_pc(bus.pc);
    stall_w    = 1'b0;
    flush_if_w = 1'b0;
    flush_id_w = 1'b0;
`ifdef FETCH_CTRL_IRQ_EN
    epc_d        = epc_q;
    int_active_d = int_active_q;
    irq_take     = bus.irq && !int_active_q;
`endif

    case (state_q)
      ST_BOOT: begin
        // The last hold cycle releases stall so the PC captures RESET_PC.
        pc_next_w  = RESET_PC;
        flush_if_w = 1'b1;
        stall_w    = (cnt_q != c_boot_last);
        cnt_d      = cnt_q + 4'd1;
        if (cnt_q == c_boot_last) begin
          cnt_d   = 4'd0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (bus.ex_branch_taken) begin
          pc_next_w  = bus.ex_branch_target;
          flush_if_w = 1'b1;
          flush_id_w = 1'b1;
          state_d    = ST_REDIR;
        end else if (bus.hazard_stall) begin
          stall_w   = 1'b1;
          pc_next_w = bus.pc;
`ifdef FETCH_CTRL_IRQ_EN
        end else if (irq_take) begin
          epc_d        = bus.pc;
          int_active_d = 1'b1;
          pc_next_w    = EXC_VECTOR;
          flush_if_w   = 1'b1;
          state_d      = ST_REDIR;
`endif
        end else if (bus.id_jump) begin
          pc_next_w  = bus.id_jump_target;
          flush_if_w = 1'b1;
          state_d    = ST_REDIR;
`ifdef FETCH_CTRL_IRQ_EN
        end else if (bus.eret) begin
          pc_next_w    = epc_q;
          int_active_d = 1'b0;
          flush_if_w   = 1'b1;
          state_d      = ST_REDIR;
`endif
        end else if (bus.halt_req) begin
          stall_w    = 1'b1;
          flush_if_w = 1'b1;
          pc_next_w  = bus.pc;
          state_d    = ST_HALT;
        end
      end

      ST_REDIR: begin
        // Kills the wrong-path word the synchronous memory is returning.
        flush_if_w = 1'b1;
        state_d    = ST_RUN;
        if (bus.ex_branch_taken) begin
          pc_next_w  = bus.ex_branch_target;
          flush_id_w = 1'b1;
          state_d    = ST_REDIR;
        end
      end

      ST_HALT: begin
        stall_w    = 1'b1;
        flush_if_w = 1'b1;
        pc_next_w  = bus.pc;
`ifdef FETCH_CTRL_IRQ_EN
        if (irq_take) begin
          epc_d        = bus.pc;
          int_active_d = 1'b1;
          pc_next_w    = EXC_VECTOR;
          stall_w      = 1'b0;
          state_d      = ST_REDIR;
        end else
`endif
        if (bus.resume) begin
          state_d = ST_RUN;
        end
      end

      default: state_d = ST_BOOT;
    endcase

    // Covers BOOT_HOLD==1, where the boot state alone would release stall.
    if (!rst) begin
      pc_next_w  = RESET_PC;
      stall_w    = 1'b1;
      flush_if_w = 1'b1;
      flush_id_w = 1'b0;
    end
  end

  assign bus.pc_next  = pc_next_w;
  assign bus.stall    = stall_w;
  assign bus.flush_if = flush_if_w;
  assign bus.flush_id = flush_id_w;
  assign bus.halted   = halted_q;
`ifdef FETCH_CTRL_IRQ_EN
  assign bus.epc      = epc_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_ctrl
// Purpose  : Randomized and directed bench for fetch_ctrl against a cycle model;
//            interrupt checks are compiled when FETCH_CTRL_IRQ_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

  localparam logic [31:0] c_reset_pc = 32'h0000_0000;
  localparam logic [31:0] c_exc_vec  = 32'h0000_0080;
  localparam int          c_hold     = 4;
  localparam logic [31:0] c_junk_pc  = 32'h5555_5550;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_ctrl_if bus ();

  fetch_ctrl u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: plain flags rather than a state variable.
  bit          m_boot   = 1'b1;
  int          m_bcnt   = 0;
  bit          m_redir  = 1'b0;
  bit          m_halt   = 1'b0;
  bit          m_ia     = 1'b0;
  logic [31:0] m_epc    = '0;
  logic [31:0] m_exp_pc = '0;
  bit          m_exp_st = 1'b1;

  logic [31:0] pc_r = c_junk_pc;

  logic [31:0] e_pc, e_epc;
  bit          e_st, e_fi, e_fid, e_h;
  bit          irq_v, eret_v;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
`ifdef FETCH_CTRL_IRQ_EN
    irq_v  = bus.irq;
    eret_v = bus.eret;
`else
    irq_v  = 1'b0;
    eret_v = 1'b0;
`endif
    e_h   = m_halt;
    e_epc = m_epc;
    e_pc  = bus.pc + 32'd4;
    e_st  = 1'b0;
    e_fi  = 1'b0;
    e_fid = 1'b0;
    if (!rst) begin
      e_pc = c_reset_pc; e_st = 1'b1; e_fi = 1'b1; e_h = 1'b0; e_epc = '0;
      m_boot = 1'b1; m_bcnt = 0; m_redir = 1'b0; m_halt = 1'b0; m_ia = 1'b0; m_epc = '0;
    end else if (m_boot) begin
      e_pc = c_reset_pc; e_fi = 1'b1;
      e_st = (m_bcnt != c_hold - 1);
      m_bcnt++;
      if (m_bcnt == c_hold) m_boot = 1'b0;
    end else if (m_halt) begin
      e_st = 1'b1; e_fi = 1'b1; e_pc = bus.pc;
      if (irq_v && !m_ia) begin
        e_st = 1'b0; e_pc = c_exc_vec; m_epc = bus.pc; m_ia = 1'b1;
        m_halt = 1'b0; m_redir = 1'b1;
      end else if (bus.resume) begin
        m_halt = 1'b0;
      end
    end else if (bus.ex_branch_taken) begin
      e_pc = bus.ex_branch_target; e_fi = 1'b1; e_fid = 1'b1; m_redir = 1'b1;
    end else if (m_redir) begin
      e_fi = 1'b1; m_redir = 1'b0;
    end else if (bus.hazard_stall) begin
      e_st = 1'b1; e_pc = bus.pc;
    end else if (irq_v && !m_ia) begin
      e_pc = c_exc_vec; e_fi = 1'b1; m_epc = bus.pc; m_ia = 1'b1; m_redir = 1'b1;
    end else if (bus.id_jump) begin
      e_pc = bus.id_jump_target; e_fi = 1'b1; m_redir = 1'b1;
    end else if (eret_v) begin
      e_pc = m_epc; e_fi = 1'b1; m_ia = 1'b0; m_redir = 1'b1;
    end else if (bus.halt_req) begin
      e_st = 1'b1; e_fi = 1'b1; e_pc = bus.pc; m_halt = 1'b1;
    end

    chk("pc_next",  bus.pc_next,         e_pc);
    chk("stall",    32'(bus.stall),      32'(e_st));
    chk("flush_if", 32'(bus.flush_if),   32'(e_fi));
    chk("flush_id", 32'(bus.flush_id),   32'(e_fid));
    chk("halted",   32'(bus.halted),     32'(e_h));
`ifdef FETCH_CTRL_IRQ_EN
    chk("epc",      bus.epc,             e_epc);
`endif
    m_exp_pc = e_pc;
    m_exp_st = e_st;
  end

  // Fetch-stage PC register, driven by the model's expected controls.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!rst)           pc_r = c_junk_pc;
    else if (!m_exp_st) pc_r = m_exp_pc;
    bus.pc = pc_r;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.hazard_stall     = 1'b0;
    bus.ex_branch_taken  = 1'b0;
    bus.ex_branch_target = '0;
    bus.id_jump          = 1'b0;
    bus.id_jump_target   = '0;
    bus.halt_req         = 1'b0;
    bus.resume           = 1'b0;
`ifdef FETCH_CTRL_IRQ_EN
    bus.irq              = 1'b0;
    bus.eret             = 1'b0;
`endif
  endtask

  logic [31:0] p_hold;

  initial begin
    bus.pc = pc_r;
    clear_inputs();

    // Reset state
    tick(); settle();
    chk("rst_pc_next", bus.pc_next, c_reset_pc);
    chk("rst_stall", 32'(bus.stall), 32'd1);
    chk("rst_flush_if", 32'(bus.flush_if), 32'd1);
    chk("rst_flush_id", 32'(bus.flush_id), 32'd0);
    chk("rst_halted", 32'(bus.halted), 32'd0);

    // Boot hold: three held cycles, stall released in the fourth
    tick(); rst = 1'b1;
    for (int i = 0; i < c_hold; i++) begin
      settle();
      chk("boot_stall", 32'(bus.stall), (i == c_hold - 1) ? 32'd0 : 32'd1);
      tick();
    end
    chk("boot_pc0", pc_r, 32'h0);
    settle(); chk("run_next4", bus.pc_next, 32'h4);
    tick(); chk("boot_pc4", pc_r, 32'h4);
    tick(); chk("boot_pc8", pc_r, 32'h8);

    // Branch beats a coincident hazard stall
    bus.ex_branch_taken = 1'b1; bus.ex_branch_target = 32'h100; bus.hazard_stall = 1'b1;
    settle();
    chk("br_stall", 32'(bus.stall), 32'd0);
    chk("br_pc_next", bus.pc_next, 32'h100);
    chk("br_fid_N", 32'(bus.flush_id), 32'd1);
    tick(); clear_inputs();
    settle();
    chk("br_pc", pc_r, 32'h100);
    chk("br_fif_N1", 32'(bus.flush_if), 32'd1);
    chk("br_fid_N1", 32'(bus.flush_id), 32'd0);
    chk("redir_next", bus.pc_next, 32'h104);
    tick(); settle();
    chk("post_redir_fif", 32'(bus.flush_if), 32'd0);

    // Jump held back by a hazard stall, taken the cycle after
    tick();
    bus.id_jump = 1'b1; bus.id_jump_target = 32'h40; bus.hazard_stall = 1'b1;
    settle();
    chk("jst_stall", 32'(bus.stall), 32'd1);
    chk("jst_fif", 32'(bus.flush_if), 32'd0);
    chk("jst_pc_next", bus.pc_next, 32'h108);
    tick(); chk("jst_pc_held", pc_r, 32'h108);
    bus.hazard_stall = 1'b0;
    settle(); chk("jmp_next", bus.pc_next, 32'h40);
    tick(); clear_inputs(); chk("jmp_pc", pc_r, 32'h40);
    settle();

    // Wrap of the sequential PC
    tick();
    bus.id_jump = 1'b1; bus.id_jump_target = 32'hFFFF_FFF8;
    settle(); tick(); clear_inputs();
    settle(); tick();
    settle();
    chk("wrap_pc", pc_r, 32'hFFFF_FFFC);
    chk("wrap_next", bus.pc_next, 32'h0);
    tick(); chk("wrap_pc0", pc_r, 32'h0);

    // Halt and resume
    bus.halt_req = 1'b1;
    settle();
    chk("halt_stall", 32'(bus.stall), 32'd1);
    chk("halt_halted_N", 32'(bus.halted), 32'd0);
    p_hold = pc_r;
    tick(); bus.halt_req = 1'b0;
    settle(); chk("halt_halted_N1", 32'(bus.halted), 32'd1);
    tick(); tick();
    chk("halt_pc_frozen", pc_r, p_hold);
    bus.resume = 1'b1;
    settle(); tick(); bus.resume = 1'b0;
    settle(); chk("resume_halted", 32'(bus.halted), 32'd0);
    tick(); chk("resume_pc4", pc_r, p_hold + 32'd4);
    tick(); chk("resume_pc8", pc_r, p_hold + 32'd8);

    // Reset asserted in the REDIR cycle
    bus.id_jump = 1'b1; bus.id_jump_target = 32'h200;
    settle(); tick(); clear_inputs();
    rst = 1'b0;
    settle();
    chk("rstr_stall", 32'(bus.stall), 32'd1);
    chk("rstr_fif", 32'(bus.flush_if), 32'd1);
    chk("rstr_fid", 32'(bus.flush_id), 32'd0);
    chk("rstr_pc_next", bus.pc_next, c_reset_pc);
    tick(); rst = 1'b1;
    for (int i = 0; i < c_hold; i++) begin
      settle(); tick();
    end
    chk("reboot_pc", pc_r, c_reset_pc);

`ifdef FETCH_CTRL_IRQ_EN
    // Interrupt entry, a masked second request, then return
    bus.id_jump = 1'b1; bus.id_jump_target = 32'h1C;
    settle(); tick(); clear_inputs();
    settle(); tick();
    chk("irq_pc_at", pc_r, 32'h20);
    bus.irq = 1'b1;
    settle(); chk("irq_next", bus.pc_next, 32'h80);
    tick();
    chk("irq_pc", pc_r, 32'h80);
    chk("irq_epc", bus.epc, 32'h20);
    settle(); tick();
    settle();
    chk("irq2_next", bus.pc_next, 32'h88);
    chk("irq2_fif", 32'(bus.flush_if), 32'd0);
    tick(); bus.irq = 1'b0; bus.eret = 1'b1;
    settle(); chk("eret_next", bus.pc_next, 32'h20);
    tick(); bus.eret = 1'b0;
    chk("eret_pc", pc_r, 32'h20);
`endif

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 249) == 0) rst = 1'b0;
      bus.hazard_stall     = ($urandom_range(0, 3) == 0);
      bus.ex_branch_taken  = ($urandom_range(0, 7) == 0);
      bus.ex_branch_target = $urandom() & 32'hFFFF_FFFC;
      bus.id_jump          = ($urandom_range(0, 5) == 0);
      bus.id_jump_target   = $urandom() & 32'hFFFF_FFFC;
      bus.halt_req         = ($urandom_range(0, 19) == 0);
      bus.resume           = ($urandom_range(0, 3) == 0);
`ifdef FETCH_CTRL_IRQ_EN
      bus.irq              = ($urandom_range(0, 9) == 0);
      bus.eret             = ($urandom_range(0, 11) == 0);
`endif
      settle();
    end

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
